cam_capture_ctrl: RTL and testbench

Frame-capture sequencer between the camera pins and the frame-buffer RAM. It arms on a software start pulse and waits for a clean frame boundary on Vsync. It then writes exactly one frame of 8-bit pixels to sequential RAM addresses and reports done or error status to the Wishbone register block. The camera signals are asynchronous and are oversampled in the clk domain; clk must be at least 4x Pclk.

---
 rtl/cam_pkg.sv | 25 ++
 rtl/cam_capture_ctrl_if.sv | 37 +++
 rtl/cam_sync_edge.sv | 48 ++++
 rtl/cam_capture_ctrl.sv | 168 ++++++++++++++++
 tb/tb_cam_capture_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_pkg.sv
// Shared types and sizing for the camera frame-capture controller.
// Defaults describe a 640x480 8-bit frame.
package cam_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_SOF,
    CAPTURE,
    DONE
  } cam_state_e;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int FRAME_BYTES  = H_ACTIVE_DEF * V_ACTIVE_DEF;

  localparam logic [9:0] LINE_MAX = 10'h3FF;

  function automatic int addr_w_for(input int bytes);
    return (bytes <= 2) ? 1 : $clog2(bytes);
  endfunction

  localparam int ADDR_W_DEF = addr_w_for(FRAME_BYTES);

endpackage

// File: rtl/cam_capture_ctrl_if.sv
// Camera pin bundle plus frame-buffer write port.
// master = capture controller, slave = camera/RAM side.
interface cam_capture_ctrl_if
  import cam_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              cam_vsync;
  logic              cam_href;
  logic              cam_pclk;
  logic [7:0]        cam_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport master (
    input  cam_vsync,
    input  cam_href,
    input  cam_pclk,
    input  cam_data,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport slave (
    output cam_vsync,
    output cam_href,
    output cam_pclk,
    output cam_data,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

endinterface

// File: rtl/cam_sync_edge.sv
// Multi-stage synchronizer with registered rise/fall detect.
// sync_o is delayed one cycle so it lines up with rise_o/fall_o.
module cam_sync_edge #(
  parameter int WIDTH       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_q, chain_d;
  logic [WIDTH-1:0] dly_q, dly_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] s;

  assign s = chain_q[SYNC_STAGES-1];

  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], async_i};
    dly_d   = s;
    rise_d  = s & ~dly_q;
    fall_d  = ~s & dly_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain_q <= '0;
      dly_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      chain_q <= chain_d;
      dly_q   <= dly_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign sync_o = dly_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/cam_capture_ctrl.sv
// Frame-capture sequencer: arms on start, syncs to a Vsync boundary,
// writes one frame of pixels to sequential RAM addresses.
module cam_capture_ctrl
  import cam_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int ADDR_W      = addr_w_for(H_ACTIVE * V_ACTIVE),
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  cam_capture_ctrl_if.master  bus,
  output logic                busy,
  output logic                done,
  output logic                err_short,
  output logic                err_over,
  output logic [9:0]          line_cnt
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FRAME = CNT_W'(H_ACTIVE * V_ACTIVE);

  logic [2:0] cam_s, cam_r, cam_f;

  cam_sync_edge #(
    .WIDTH       (3),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i ({bus.cam_vsync, bus.cam_href, bus.cam_pclk}),
    .sync_o  (cam_s),
    .rise_o  (cam_r),
    .fall_o  (cam_f)
  );

  logic vs_rise, vs_fall, href_s, href_fall, pclk_rise;
  assign vs_rise   = cam_r[2];
  assign vs_fall   = cam_f[2];
  assign href_s    = cam_s[1];
  assign href_fall = cam_f[1];
  assign pclk_rise = cam_r[0];

  logic unused_edges;
  assign unused_edges = ^{cam_s[2], cam_s[0], cam_r[1], cam_f[0]};

  // One extra stage keeps data aligned with the registered edge pulses
  logic [SYNC_STAGES:0][7:0] dat_q, dat_d;
  logic [7:0] data_s;
  assign data_s = dat_q[SYNC_STAGES];

  cam_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [9:0]        line_q, line_d;
  logic              done_q, done_d;
  logic              short_q, short_d;
  logic              over_q, over_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;

  always_comb begin
    dat_d   = {dat_q[SYNC_STAGES-1:0], bus.cam_data};
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    done_d  = done_q;
    short_d = short_q;
    over_d  = over_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      line_d  = '0;
      done_d  = 1'b0;
      short_d = 1'b0;
      over_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = ARM;
            cnt_d   = '0;
            line_d  = '0;
            done_d  = 1'b0;
            short_d = 1'b0;
            over_d  = 1'b0;
          end
        end
        ARM: begin
          if (vs_rise) state_d = WAIT_SOF;
        end
        WAIT_SOF: begin
          if (vs_fall) begin
            state_d = CAPTURE;
            cnt_d   = '0;
          end
        end
        CAPTURE: begin
          if (pclk_rise && href_s) begin
            if (cnt_q < FRAME) begin
              we_d    = 1'b1;
              addr_d  = cnt_q[ADDR_W-1:0];
              wdata_d = data_s;
              cnt_d   = cnt_q + 1'b1;
            end else begin
              over_d  = 1'b1;
            end
          end
          if (href_fall && line_q != LINE_MAX)
            line_d = line_q + 1'b1;
          // End-of-frame check sees a pixel landing in the same cycle
          if (vs_rise) begin
            state_d = DONE;
            if (cnt_d == FRAME && !over_d) done_d = 1'b1;
            if (cnt_d < FRAME) short_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dat_q   <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      done_q  <= 1'b0;
      short_q <= 1'b0;
      over_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      dat_q   <= dat_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      done_q  <= done_d;
      short_q <= short_d;
      over_q  <= over_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy = (state_q == ARM) ||
                (state_q == WAIT_SOF) ||
                (state_q == CAPTURE);

  assign done          = done_q;
  assign err_short     = short_q;
  assign err_over      = over_q;
  assign line_cnt      = line_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Directed bench for cam_capture_ctrl: 4x3 frame, clk = 8x Pclk,
// frame-level write model plus per-write compare.
module tb_cam_capture_ctrl;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int FB = H * V;
  localparam int AW = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       busy, done, err_short, err_over;
  logic [9:0] line_cnt;

  cam_capture_ctrl_if #(.ADDR_W(AW)) bus ();

  cam_capture_ctrl #(
    .H_ACTIVE    (H),
    .V_ACTIVE    (V),
    .ADDR_W      (AW),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .err_short (err_short),
    .err_over  (err_over),
    .line_cnt  (line_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  m_cnt   = 0;
  int  m_lines = 0;
  bit  m_over  = 0;

  int n_wr = 0;
  int first_addr = -1, first_data = -1;
  int last_addr = -1, last_data = -1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.mem_we !== 1'b0) begin
      n_wr++;
      if (n_wr == 1) begin
        first_addr = int'(bus.mem_addr);
        first_data = int'(bus.mem_wdata);
      end
      last_addr = int'(bus.mem_addr);
      last_data = int'(bus.mem_wdata);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0d data %0d, expected no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", {28'd0, bus.mem_addr}, e.addr);
        chk("wr_data", {24'd0, bus.mem_wdata}, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One Pclk period: data/href change on the falling edge
  task automatic pix(input logic [7:0] d, input bit h, input bit cap);
    wr_t w;
    bus.cam_data = d;
    bus.cam_href = h;
    bus.cam_pclk = 1'b0;
    if (cap && h) begin
      if (m_cnt < FB) begin
        w.addr = m_cnt;
        w.data = int'(d);
        exp_q.push_back(w);
      end else begin
        m_over = 1'b1;
      end
      m_cnt++;
    end
    repeat (4) tick();
    bus.cam_pclk = 1'b1;
    repeat (4) tick();
  endtask

  task automatic blank();
    pix(8'h00, 1'b0, 1'b0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic pixels(input int n, input int base, input bit cap,
                        input int start_at);
    for (int i = 0; i < n; i++) begin
      if (i == start_at) pulse_start();
      pix(8'(base + i), 1'b1, cap);
      if ((i % H) == H - 1 || i == n - 1) begin
        blank();
        if (cap) m_lines++;
      end
    end
  endtask

  task automatic model_clear();
    m_cnt   = 0;
    m_lines = 0;
    m_over  = 0;
  endtask

  task automatic arm();
    bus.cam_vsync = 1'b0;
    blank();
    pulse_start();
    model_clear();
    chk("arm_busy", busy, 1);
    chk("arm_done_clr", done, 0);
    chk("arm_short_clr", err_short, 0);
    chk("arm_over_clr", err_over, 0);
    blank();
    bus.cam_vsync = 1'b1;
    blank();
    blank();
  endtask

  task automatic frame(input int n, input int base, input int start_at);
    bus.cam_vsync = 1'b0;
    blank();
    pixels(n, base, 1'b1, start_at);
    bus.cam_vsync = 1'b1;
    blank();
    blank();
  endtask

  task automatic status(input string tag, input bit b, input bit d,
                        input bit s, input bit o, input int lines);
    chk({tag, "_busy"}, busy, b);
    chk({tag, "_done"}, done, d);
    chk({tag, "_short"}, err_short, s);
    chk({tag, "_over"}, err_over, o);
    chk({tag, "_lines"}, line_cnt, lines);
  endtask

  task automatic frame_end(input string tag);
    chk({tag, "_pending_writes"}, exp_q.size(), 0);
    status(tag, 1'b0, (m_cnt == FB) && !m_over, m_cnt < FB, m_over,
           m_lines);
  endtask

  initial begin
    bus.cam_vsync = 1'b0;
    bus.cam_href  = 1'b0;
    bus.cam_pclk  = 1'b0;
    bus.cam_data  = 8'h00;
    repeat (3) tick();
    status("reset", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("reset_we", bus.mem_we, 0);
    chk("reset_addr", bus.mem_addr, 0);
    chk("reset_wdata", bus.mem_wdata, 0);
    reset = 1'b1;
    repeat (2) tick();

    // Full frame 0x00..0x0B
    arm();
    n_wr = 0;
    frame(FB, 8'h00, -1);
    frame_end("t1");
    chk("t1_done_lit", done, 1);
    chk("t1_lines_lit", line_cnt, 3);
    chk("t1_nwr", n_wr, 12);
    chk("t1_last_addr", last_addr, 11);
    chk("t1_last_data", last_data, 8'h0B);

    // Start mid-frame: nothing until next vs_rise then vs_fall
    bus.cam_vsync = 1'b0;
    blank();
    n_wr = 0;
    pulse_start();
    model_clear();
    chk("t2_busy", busy, 1);
    chk("t2_done_clr", done, 0);
    pixels(6, 8'h80, 1'b0, -1);
    bus.cam_vsync = 1'b1;
    blank();
    blank();
    chk("t2_no_early_wr", n_wr, 0);
    frame(FB, 8'h20, -1);
    frame_end("t2");
    chk("t2_first_addr", first_addr, 0);
    chk("t2_first_data", first_data, 8'h20);

    // Short frame: 2 lines
    arm();
    n_wr = 0;
    frame(8, 8'h40, -1);
    frame_end("t3");
    chk("t3_nwr", n_wr, 8);
    chk("t3_short_lit", err_short, 1);
    chk("t3_done_lit", done, 0);

    // Overlong frame: 13 bytes
    arm();
    n_wr = 0;
    frame(13, 8'h50, -1);
    frame_end("t4");
    chk("t4_nwr", n_wr, 12);
    chk("t4_last_addr", last_addr, 11);
    chk("t4_last_data", last_data, 8'h5B);
    chk("t4_over_lit", err_over, 1);
    chk("t4_done_lit", done, 0);

    // Abort after 5 pixels
    arm();
    n_wr = 0;
    bus.cam_vsync = 1'b0;
    blank();
    pixels(5, 8'h60, 1'b1, -1);
    repeat (4) tick();
    chk("t5_pre_lines", line_cnt, 2);
    pulse_abort();
    status("t5_abort", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("t5_pending_writes", exp_q.size(), 0);
    chk("t5_nwr", n_wr, 5);
    pixels(4, 8'h70, 1'b0, -1);
    bus.cam_vsync = 1'b1;
    blank();
    blank();
    chk("t5_nwr_after", n_wr, 5);
    status("t5_idle", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    arm();
    n_wr = 0;
    frame(FB, 8'h90, -1);
    frame_end("t5b");
    chk("t5b_first_addr", first_addr, 0);
    chk("t5b_first_data", first_data, 8'h90);
    chk("t5b_done_lit", done, 1);

    // Reset mid-capture
    arm();
    n_wr = 0;
    bus.cam_vsync = 1'b0;
    blank();
    pixels(3, 8'hA0, 1'b1, -1);
    repeat (4) tick();
    reset = 1'b0;
    #1;
    status("t6_rst", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("t6_rst_we", bus.mem_we, 0);
    chk("t6_rst_addr", bus.mem_addr, 0);
    tick();
    reset = 1'b1;
    chk("t6_nwr", n_wr, 3);
    chk("t6_pending_writes", exp_q.size(), 0);
    pixels(4, 8'hB0, 1'b0, -1);
    bus.cam_vsync = 1'b1;
    blank();
    blank();
    chk("t6_nwr_after", n_wr, 3);

    // Start while busy is ignored
    arm();
    n_wr = 0;
    frame(FB, 8'hC0, 6);
    frame_end("t7");
    chk("t7_nwr", n_wr, 12);
    chk("t7_done_lit", done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
